adc_rx: RTL and testbench
=========================

Name: adc_rx

Overview:
- Receive-side counterpart of the DAC output driver. It captures a 14-bit offset-binary parallel ADC bus and the ADC out-of-range pin.
- It converts each sample to the signed 17-bit datapath format the DAC driver accepts as data_in: two's complement, full scale at bits 15:2.
- It optionally averages 2^DECIM_LOG2 samples per output.
- It sequences the ADC power-down pin through a wake/flush state machine gated by PLLLOCK and en.

Parameters:
- DECIM_LOG2, 0, log2 of samples averaged per output word; legal range 0..4.
- WAKE_CYCLES, 1000, clk cycles ADC_PDWN is held low before samples are considered.
- FLUSH_SAMPLES, 8, samples discarded after wake. Covers the ADC pipeline latency.

Ports:
- clk  in  1  sample clock; ADC data is valid at its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  receive enable.
- PLLLOCK  in  1  clock PLL lock; receiver runs only while high.
- adc_d  in  14  ADC parallel data, offset binary (0x2000 = mid-scale).
- adc_otr  in  1  ADC out-of-range pin, aligned with adc_d.
- ovr_clr  in  1  single-cycle pulse that clears ovr_sticky.
- data_o  out  17  signed sample/average.
- data_valid  out  1  one-cycle strobe qualifying data_o.
- sample_otr  out  1  OR of adc_otr over the samples forming data_o; qualified by data_valid.
- ovr_sticky  out  1  latched out-of-range flag.
- ADC_PDWN  out  1  ADC power-down pin, active high.
- state_o  out  2  FSM state (0 IDLE, 1 WAKE, 2 FLUSH, 3 RUN).

Behaviour:
- Reset (async, rst_n=0) values:
  - All outputs 0, except ADC_PDWN=1.
  - state IDLE.
  - Counters, accumulator and capture registers cleared.
- Input capture: adc_d and adc_otr are registered every clk edge, unconditionally (capture stage).
- Conversion:
  - s14 = {~cap_d[13], cap_d[12:0]}.
  - sample17 = {s14[13], s14, 2'b00}.
  - 0x0000 -> 0x18000 (-32768); 0x2000 -> 0x00000; 0x3FFF -> 0x07FFC (+32764).
- FSM, evaluated each edge. go = en & PLLLOCK.
  - IDLE: ADC_PDWN=1. If go, next state WAKE and the wake counter is loaded with 0.
  - WAKE: ADC_PDWN=0. The wake counter increments each cycle; leave for FLUSH when count reaches WAKE_CYCLES-1.
  - FLUSH: ADC_PDWN=0. Each captured sample is discarded and increments the flush counter. Leave for RUN after FLUSH_SAMPLES samples.
  - RUN: ADC_PDWN=0. Samples feed the accumulator.
  - !go in any state: next state IDLE. Accumulator, sample counter and sample_otr accumulation are cleared. data_valid is forced 0 from the following edge. A partial average in progress is dropped, never output.
- Accumulation in RUN:
  - Accumulator width 17+DECIM_LOG2, signed.
  - The first sample of a group loads the accumulator; subsequent samples add to it.
  - After the 2^DECIM_LOG2-th sample: data_o = acc >>> DECIM_LOG2 (arithmetic shift, truncation toward -inf), data_valid=1 for one cycle.
  - The accumulator reloads with the next sample on the same edge; no gap between groups.
- Latency:
  - DECIM_LOG2=0: adc_d presented at edge N gives data_o/data_valid updated at edge N+2. First valid output at edge N+2, where edge N is the first RUN capture.
  - DECIM_LOG2>0: the output follows the last sample of the group by the same 2 edges.
- data_o holds its last value when data_valid=0.
- sample_otr is the OR of cap_otr over the group, registered with data_o.
- ovr_sticky:
  - Set when a captured sample in RUN has adc_otr=1.
  - Cleared by ovr_clr.
  - Set and clear in the same cycle: set wins.
  - Not cleared by leaving RUN; only by ovr_clr or reset.
  - adc_otr during IDLE, WAKE or FLUSH is ignored.
- PLLLOCK is used as a level with no internal synchroniser; it is produced in the clk domain.

Test Plan:
- Reset: rst_n=0 mid-RUN with data_valid high.
  - Required: asynchronously data_valid=0, data_o=0, ADC_PDWN=1, state_o=0.
  - Required: after rst_n=1 with go held high, WAKE is entered on the next edge.
- Wake sequence: WAKE_CYCLES=10, FLUSH_SAMPLES=4, en=PLLLOCK=1.
  - Required: ADC_PDWN falls on the first edge.
  - Required: state_o goes 1, then 2 after 10 cycles, then 3 after 4 more.
  - Required: no data_valid before RUN.
- Conversion, DECIM_LOG2=0: adc_d = 0x0000, 0x2000, 0x3FFF, 0x1FFF on consecutive RUN cycles.
  - Required: data_o = 0x18000, 0x00000, 0x07FFC, 0x1FFFC, each 2 edges later, with data_valid high 4 consecutive cycles.
- Averaging, DECIM_LOG2=2: adc_d = 0x2004, 0x2004, 0x1FFC, 0x2001.
  - Required: sum of samples 16+16-16+4 = 20, so data_o = 5 (0x00005), one data_valid pulse.
  - Required: a following group 0x1FFF x4 gives data_o = 0x1FFFC.
- Abort: PLLLOCK drops after 2 of 4 samples.
  - Required: no data_valid; state_o=0; ADC_PDWN=1 next edge.
  - Required: after relock and re-wake, the first average contains only new samples.
- Overrange: adc_otr=1 on one RUN sample, ovr_clr pulsed in the same cycle it is captured.
  - Required: ovr_sticky=1 (set wins); sample_otr=1 on that group's data_valid.
  - Required: a later lone ovr_clr gives ovr_sticky=0.
  - Required: adc_otr=1 during FLUSH does not set ovr_sticky.

Source files
------------

// File: rtl/adc_rx.sv
// adc_rx: offset-binary ADC capture, conversion to the signed 17-bit datapath
// format, optional 2^DECIM_LOG2 averaging, and ADC power-down sequencing.
module adc_rx #(
   parameter int unsigned DECIM_LOG2    = 0,
   parameter int unsigned WAKE_CYCLES   = 1000,
   parameter int unsigned FLUSH_SAMPLES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        PLLLOCK,
   input  logic [13:0] adc_d,
   input  logic        adc_otr,
   input  logic        ovr_clr,
   output logic [16:0] data_o,
   output logic        data_valid,
   output logic        sample_otr,
   output logic        ovr_sticky,
   output logic        ADC_PDWN,
   output logic [1:0]  state_o
);

   localparam int unsigned AccW   = 17 + DECIM_LOG2;
   localparam int unsigned CntW   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int unsigned WakeW  = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam int unsigned FlushW = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;

   localparam logic [CntW-1:0]   GroupLast = CntW'((1 << DECIM_LOG2) - 1);
   localparam logic [WakeW-1:0]  WakeLast  = WakeW'(WAKE_CYCLES - 1);
   localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_SAMPLES - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWake  = 2'd1,
      StFlush = 2'd2,
      StRun   = 2'd3
   } state_e;

   state_e              state_q;
   logic [WakeW-1:0]    wake_cnt_q;
   logic [FlushW-1:0]   flush_cnt_q;
   logic                pdwn_q;

   logic [13:0]         cap_d_q;
   logic                cap_otr_q;
   logic signed [AccW-1:0] acc_q;
   logic [CntW-1:0]     cnt_q;
   logic                otr_acc_q;
   logic                full_q;
   logic [16:0]         data_q;
   logic                valid_q;
   logic                sotr_q;
   logic                sticky_q;

   logic                go;
   logic                run_sample;
   logic [13:0]         s14;
   logic signed [16:0]  sample17;
   logic signed [AccW-1:0] sample_ext;
   logic [16:0]         avg17;

   assign go         = en & PLLLOCK;
   assign run_sample = go && (state_q == StRun);
   assign s14        = {~cap_d_q[13], cap_d_q[12:0]};
   assign sample17   = {s14[13], s14, 2'b00};
   assign sample_ext = sample17;
   assign avg17      = 17'(acc_q >>> DECIM_LOG2);

   // Power sequencing: IDLE -> WAKE (settle) -> FLUSH (drain ADC pipeline) -> RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wake_cnt_q  <= '0;
         flush_cnt_q <= '0;
         pdwn_q      <= 1'b1;
      end else if (!go) begin
         state_q <= StIdle;
         pdwn_q  <= 1'b1;
      end else begin
         pdwn_q <= 1'b0;
         case (state_q)
            StIdle: begin
               state_q    <= StWake;
               wake_cnt_q <= '0;
            end
            StWake: begin
               if (wake_cnt_q == WakeLast) begin
                  state_q     <= StFlush;
                  flush_cnt_q <= '0;
               end else begin
                  wake_cnt_q <= wake_cnt_q + 1'b1;
               end
            end
            StFlush: begin
               if (flush_cnt_q == FlushLast) begin
                  state_q <= StRun;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            StRun:   state_q <= StRun;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Unconditional capture of the ADC bus and out-of-range pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_d_q   <= '0;
         cap_otr_q <= 1'b0;
      end else begin
         cap_d_q   <= adc_d;
         cap_otr_q <= adc_otr;
      end
   end

   // Group accumulation; a complete group is emitted one edge after its last add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         otr_acc_q <= 1'b0;
         full_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         sotr_q    <= 1'b0;
      end else if (!go) begin
         // Any partial group is dropped.
         acc_q     <= '0;
         cnt_q     <= '0;
         otr_acc_q <= 1'b0;
         full_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= full_q;
         if (full_q) begin
            data_q <= avg17;
            sotr_q <= otr_acc_q;
         end
         full_q <= 1'b0;
         if (state_q == StRun) begin
            if (cnt_q == '0) begin
               acc_q     <= sample_ext;
               otr_acc_q <= cap_otr_q;
            end else begin
               acc_q     <= acc_q + sample_ext;
               otr_acc_q <= otr_acc_q | cap_otr_q;
            end
            full_q <= (cnt_q == GroupLast);
            cnt_q  <= (cnt_q == GroupLast) ? '0 : cnt_q + 1'b1;
         end
      end
   end

   // Sticky overrange: only RUN samples set it; a coincident clear loses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else if (run_sample && cap_otr_q) begin
         sticky_q <= 1'b1;
      end else if (ovr_clr) begin
         sticky_q <= 1'b0;
      end
   end

   assign data_o     = data_q;
   assign data_valid = valid_q;
   assign sample_otr = sotr_q;
   assign ovr_sticky = sticky_q;
   assign ADC_PDWN   = pdwn_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_adc_rx.sv
// tb_adc_rx: two receivers (no averaging and 4-sample averaging) driven by the
// same stream, checked against a sample-level reference model via scoreboards.
module tb_adc_rx;

   localparam int Wake  = 10;
   localparam int Flush = 4;
   localparam int RunAt = Wake + Flush + 2;  // go-run length at which a sample is consumed

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        PLLLOCK = 1'b0;
   logic [13:0] adc_d = '0;
   logic        adc_otr = 1'b0;
   logic        ovr_clr = 1'b0;

   logic [16:0] d0_data, d2_data;
   logic        d0_valid, d2_valid, d0_sotr, d2_sotr, d0_sticky, d2_sticky, d0_pdwn, d2_pdwn;
   logic [1:0]  d0_state, d2_state;

   always #5 clk = ~clk;

   adc_rx #(.DECIM_LOG2(0), .WAKE_CYCLES(Wake), .FLUSH_SAMPLES(Flush)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .PLLLOCK(PLLLOCK), .adc_d(adc_d), .adc_otr(adc_otr),
      .ovr_clr(ovr_clr), .data_o(d0_data), .data_valid(d0_valid), .sample_otr(d0_sotr),
      .ovr_sticky(d0_sticky), .ADC_PDWN(d0_pdwn), .state_o(d0_state)
   );

   adc_rx #(.DECIM_LOG2(2), .WAKE_CYCLES(Wake), .FLUSH_SAMPLES(Flush)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .PLLLOCK(PLLLOCK), .adc_d(adc_d), .adc_otr(adc_otr),
      .ovr_clr(ovr_clr), .data_o(d2_data), .data_valid(d2_valid), .sample_otr(d2_sotr),
      .ovr_sticky(d2_sticky), .ADC_PDWN(d2_pdwn), .state_o(d2_state)
   );

   typedef struct {
      logic [16:0] val;
      logic        otr;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   // Reference model state
   int          run_len = 0;
   logic [13:0] prev_d = '0;
   logic        prev_otr = 1'b0;
   int          g_sum = 0;
   int          g_n = 0;
   logic        g_otr = 1'b0;
   logic        exp_sticky = 1'b0;
   logic [16:0] last0 = '0;
   logic [16:0] last2 = '0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Sample-level model: a sample is used once go has been held through wake and flush.
   always @(posedge clk) begin
      int   v;
      int   a;
      exp_t e;
      cyc++;
      if (!rst_n) begin
         run_len = 0;
         q0.delete();
         q2.delete();
         g_sum = 0; g_n = 0; g_otr = 1'b0;
         exp_sticky = 1'b0;
      end else begin
         if (!(en && PLLLOCK)) begin
            run_len = 0;
            g_sum = 0; g_n = 0; g_otr = 1'b0;
            while (q0.size() > 0 && q0[0].due == cyc) void'(q0.pop_front());
            while (q2.size() > 0 && q2[0].due == cyc) void'(q2.pop_front());
         end else if (run_len < 1000) begin
            run_len++;
         end
         if (run_len >= RunAt) begin
            v = (int'(prev_d) - 8192) * 4;
            e.val = v[16:0]; e.otr = prev_otr; e.due = cyc + 1;
            q0.push_back(e);
            g_sum += v; g_otr |= prev_otr; g_n++;
            if (g_n == 4) begin
               a = g_sum >>> 2;
               e.val = a[16:0]; e.otr = g_otr; e.due = cyc + 1;
               q2.push_back(e);
               g_sum = 0; g_n = 0; g_otr = 1'b0;
            end
            if (prev_otr) exp_sticky = 1'b1;
            else if (ovr_clr) exp_sticky = 1'b0;
         end else if (ovr_clr) begin
            exp_sticky = 1'b0;
         end
         prev_d = adc_d;
         prev_otr = adc_otr;
      end
   end

   // Monitor: pops expected words whenever a receiver strobes data_valid.
   always @(negedge clk) begin
      int   st;
      exp_t e;
      if (!rst_n) begin
         last0 = '0; last2 = '0;
         q0.delete(); q2.delete();
      end
      st = (!rst_n || run_len == 0) ? 0 : (run_len <= Wake) ? 1 :
           (run_len <= Wake + Flush) ? 2 : 3;
      chk("d0_state", int'(d0_state), st);
      chk("d2_state", int'(d2_state), st);
      chk("d0_pdwn", int'(d0_pdwn), int'(st == 0));
      chk("d2_pdwn", int'(d2_pdwn), int'(st == 0));
      chk("d0_sticky", int'(d0_sticky), int'(exp_sticky));
      chk("d2_sticky", int'(d2_sticky), int'(exp_sticky));
      if (d0_valid) begin
         if (q0.size() == 0) begin
            chk("d0_unexpected_valid", int'(d0_valid), 0);
         end else begin
            e = q0.pop_front();
            chk("d0_data", int'(d0_data), int'(e.val));
            chk("d0_sample_otr", int'(d0_sotr), int'(e.otr));
            chk("d0_latency", cyc, e.due);
            last0 = e.val;
         end
      end else begin
         if (q0.size() > 0 && q0[0].due <= cyc) begin
            chk("d0_missing_valid", int'(d0_valid), 1);
            void'(q0.pop_front());
         end
         chk("d0_hold", int'(d0_data), int'(last0));
      end
      if (d2_valid) begin
         if (q2.size() == 0) begin
            chk("d2_unexpected_valid", int'(d2_valid), 0);
         end else begin
            e = q2.pop_front();
            chk("d2_data", int'(d2_data), int'(e.val));
            chk("d2_sample_otr", int'(d2_sotr), int'(e.otr));
            chk("d2_latency", cyc, e.due);
            last2 = e.val;
         end
      end else begin
         if (q2.size() > 0 && q2[0].due <= cyc) begin
            chk("d2_missing_valid", int'(d2_valid), 1);
            void'(q2.pop_front());
         end
         chk("d2_hold", int'(d2_data), int'(last2));
      end
   end

   // One stimulus cycle, applied away from the sampling edge.
   task automatic step(input logic [13:0] d, input logic o, input logic c,
                       input logic lock, input logic ena);
      @(negedge clk);
      #1;
      adc_d = d; adc_otr = o; ovr_clr = c; PLLLOCK = lock; en = ena;
   endtask

   task automatic wake_up();
      for (int i = 0; i < Wake + Flush; i++)
         step(14'($urandom), (i >= Flush + Wake - 2), 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      int   down;
      logic found;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(14'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);

      wake_up();
      // Conversion corners
      step(14'h0000, 0, 0, 1, 1); step(14'h2000, 0, 0, 1, 1);
      step(14'h3FFF, 0, 0, 1, 1); step(14'h1FFF, 0, 0, 1, 1);
      // Averaging groups
      step(14'h2004, 0, 0, 1, 1); step(14'h2004, 0, 0, 1, 1);
      step(14'h1FFC, 0, 0, 1, 1); step(14'h2001, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(14'h1FFF, 0, 0, 1, 1);
      // Overrange with a coincident clear, then a lone clear
      step(14'h2100, 1, 0, 1, 1); step(14'h2100, 0, 1, 1, 1);
      step(14'h2100, 0, 0, 1, 1); step(14'h2100, 0, 0, 1, 1);
      step(14'h2200, 0, 0, 1, 1); step(14'h2200, 0, 1, 1, 1);
      step(14'h2200, 0, 0, 1, 1); step(14'h2200, 0, 0, 1, 1);
      // Abort mid-group
      step(14'h3000, 0, 0, 1, 1); step(14'h3000, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(14'h3000, 0, 0, 0, 1);
      wake_up();
      for (int i = 0; i < 12; i++) step(14'($urandom), 0, 0, 1, 1);

      // Randomized run with occasional enable / lock drops
      down = 0;
      for (int i = 0; i < 500; i++) begin
         logic which;
         which = 1'($urandom);
         if (down > 0) begin
            down--;
            step(14'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                 which, ~which);
         end else begin
            if ($urandom_range(0, 79) == 0) down = $urandom_range(1, 4);
            step(14'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                 1'b1, 1'b1);
         end
      end

      // Asynchronous reset while a word is being presented
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(14'($urandom), 0, 0, 1, 1);
         if (d0_valid) found = 1'b1;
      end
      chk("wait_valid_before_reset", int'(found), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", int'(d0_valid), 0);
      chk("async_rst_data", int'(d0_data), 0);
      chk("async_rst_pdwn", int'(d0_pdwn), 1);
      chk("async_rst_state", int'(d0_state), 0);
      chk("async_rst_sticky", int'(d2_sticky), 0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 30; i++) step(14'($urandom), 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(14'($urandom), 0, 0, 0, 0);
      chk("q0_drained", q0.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
